// File: rtl/reg_bank_nxw.sv
// N-word x W-bit register bank: one write port, two registered read ports with a VALID pulse.
// Define REG_BANK_BYPASS_EN for same-edge write-to-read forwarding; ADDR_WIDTH sizes addresses (ADDR_W is the write-address port).
module reg_bank_nxw #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [WIDTH-1:0]      DATA_W,
  output logic [WIDTH-1:0]      DATA_R1,
  output logic [WIDTH-1:0]      DATA_R2,
  output logic                  VALID
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok_c;
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;

  // An address maps to real storage only when in range and not the hardwired zero word.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    wr_ok_c = WRITE && addr_ok(ADDR_W);
    rd1_c   = '0;
    rd2_c   = '0;
    if (addr_ok(ADDR_R1)) rd1_c = mem[ADDR_R1[IDX_W-1:0]];
    if (addr_ok(ADDR_R2)) rd2_c = mem[ADDR_R2[IDX_W-1:0]];
`ifdef REG_BANK_BYPASS_EN
    // Forward only writes that actually land in storage.
    if (wr_ok_c && (ADDR_R1 == ADDR_W)) rd1_c = DATA_W;
    if (wr_ok_c && (ADDR_R2 == ADDR_W)) rd2_c = DATA_W;
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok_c) begin
      mem[ADDR_W[IDX_W-1:0]] <= DATA_W;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DATA_R1 <= '0;
      DATA_R2 <= '0;
      VALID   <= 1'b0;
    end else begin
      VALID <= READ;
      if (READ) begin
        DATA_R1 <= rd1_c;
        DATA_R2 <= rd2_c;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_nxw.sv
// Bench for reg_bank_nxw: three configurations checked against an array model every cycle plus literal pins.
// Expected same-edge results follow REG_BANK_BYPASS_EN when the bench is built with it.
module tb_reg_bank_nxw;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance 0: 32x32 zero-reg; 1: 8-bit x 4 zero-reg; 2: 32-bit x 16, 5-bit addr, no zero-reg.
  logic        rd [3];
  logic        wr [3];
  logic [31:0] ar1 [3];
  logic [31:0] ar2 [3];
  logic [31:0] aw [3];
  logic [31:0] dw [3];

  logic [31:0] qa1, qa2, qc1, qc2;
  logic [7:0]  qb1, qb2;
  logic        va, vb, vc;

  int n_cmp = 0;
  int n_bad = 0;

  reg_bank_nxw #(.WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) u_a (
    .CLK(clk), .RESET(rst_n), .READ(rd[0]), .WRITE(wr[0]),
    .ADDR_R1(ar1[0][4:0]), .ADDR_R2(ar2[0][4:0]), .ADDR_W(aw[0][4:0]),
    .DATA_W(dw[0]), .DATA_R1(qa1), .DATA_R2(qa2), .VALID(va));

  reg_bank_nxw #(.WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .ZERO_REG(1'b1)) u_b (
    .CLK(clk), .RESET(rst_n), .READ(rd[1]), .WRITE(wr[1]),
    .ADDR_R1(ar1[1][1:0]), .ADDR_R2(ar2[1][1:0]), .ADDR_W(aw[1][1:0]),
    .DATA_W(dw[1][7:0]), .DATA_R1(qb1), .DATA_R2(qb2), .VALID(vb));

  reg_bank_nxw #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) u_c (
    .CLK(clk), .RESET(rst_n), .READ(rd[2]), .WRITE(wr[2]),
    .ADDR_R1(ar1[2][4:0]), .ADDR_R2(ar2[2][4:0]), .ADDR_W(aw[2][4:0]),
    .DATA_W(dw[2]), .DATA_R1(qc1), .DATA_R2(qc2), .VALID(vc));

  function automatic int unsigned dep(input int k);
    return (k == 0) ? 32 : (k == 1) ? 4 : 16;
  endfunction

  function automatic bit zr(input int k);
    return k != 2;
  endfunction

  function automatic logic [31:0] msk(input int k);
    return (k == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Behavioural model: word array per instance, expected outputs after each edge.
  logic [31:0] mm [3][32];
  logic [31:0] e1 [3];
  logic [31:0] e2 [3];
  logic        ev [3];
  bit          m_wok;

  function automatic logic [31:0] mread(input int k, input logic [31:0] a);
    if (a >= dep(k) || (zr(k) && a == 0)) return 32'h0;
    return mm[k][a[4:0]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
        e1[k] = 32'h0; e2[k] = 32'h0; ev[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_wok = wr[k] && (aw[k] < dep(k)) && !(zr(k) && aw[k] == 0);
        ev[k] = rd[k];
        if (rd[k]) begin
          e1[k] = (BYP && m_wok && ar1[k] == aw[k]) ? (dw[k] & msk(k)) : mread(k, ar1[k]);
          e2[k] = (BYP && m_wok && ar2[k] == aw[k]) ? (dw[k] & msk(k)) : mread(k, ar2[k]);
        end
        if (m_wok) mm[k][aw[k][4:0]] = dw[k] & msk(k);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_r1", qa1, e1[0]);
    chk("a_r2", qa2, e2[0]);
    chk("a_v", 32'(va), 32'(ev[0]));
    chk("b_r1", 32'(qb1), e1[1]);
    chk("b_r2", 32'(qb2), e2[1]);
    chk("b_v", 32'(vb), 32'(ev[1]));
    chk("c_r1", qc1, e1[2]);
    chk("c_r2", qc2, e2[2]);
    chk("c_v", 32'(vc), 32'(ev[2]));
  end

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ar1[k] = 0; ar2[k] = 0; aw[k] = 0; dw[k] = 0;
    end
    idle();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_reset_r1", qa1, 32'h0);
    chk("lit_reset_v", 32'(va), 32'h0);
    rst_n = 1'b1;

    // First edge after release reads 3 and 31.
    rd[0] = 1; ar1[0] = 3; ar2[0] = 31;
    @(negedge clk);
    chk("lit_first_r1", qa1, 32'h0);
    chk("lit_first_r2", qa2, 32'h0);
    chk("lit_first_v", 32'(va), 32'h1);
    chk("lit_model_v", 32'(ev[0]), 32'h1);

    idle(); wr[0] = 1; aw[0] = 5; dw[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("lit_noread_v", 32'(va), 32'h0);
    idle(); rd[0] = 1; ar1[0] = 5; ar2[0] = 5;
    @(negedge clk);
    chk("lit_beef_r1", qa1, 32'hDEADBEEF);
    chk("lit_beef_r2", qa2, 32'hDEADBEEF);
    chk("lit_beef_v", 32'(va), 32'h1);
    chk("lit_model_beef", e1[0], 32'hDEADBEEF);
    idle();
    @(negedge clk);
    chk("lit_pulse_v", 32'(va), 32'h0);
    chk("lit_hold_r1", qa1, 32'hDEADBEEF);

    // Zero register discards writes.
    wr[0] = 1; aw[0] = 0; dw[0] = 32'h12345678;
    @(negedge clk);
    idle(); rd[0] = 1; ar1[0] = 0; ar2[0] = 5;
    @(negedge clk);
    chk("lit_zero_r1", qa1, 32'h0);
    chk("lit_zero_r2", qa2, 32'hDEADBEEF);

    // Depth-16 bank: write to 20 ignored, no aliasing onto 4; word 0 is writable here.
    idle(); wr[2] = 1; aw[2] = 20; dw[2] = 32'hCAFEF00D;
    @(negedge clk);
    wr[2] = 1; aw[2] = 0; dw[2] = 32'h11;
    @(negedge clk);
    idle(); rd[2] = 1; ar1[2] = 4; ar2[2] = 0;
    @(negedge clk);
    chk("lit_oor_alias", qc1, 32'h0);
    chk("lit_c_word0", qc2, 32'h11);
    ar1[2] = 20; ar2[2] = 15;
    @(negedge clk);
    chk("lit_oor_read", qc1, 32'h0);
    chk("lit_c_15", qc2, 32'h0);

    // Same-edge write and read of word 7.
    idle(); wr[0] = 1; aw[0] = 7; dw[0] = 32'h1;
    @(negedge clk);
    wr[0] = 1; aw[0] = 7; dw[0] = 32'hA5A5A5A5; rd[0] = 1; ar1[0] = 7; ar2[0] = 6;
    @(negedge clk);
    chk("lit_same_edge_r1", qa1, BYP ? 32'hA5A5A5A5 : 32'h1);
    chk("lit_same_edge_r2", qa2, 32'h0);
    idle(); rd[0] = 1; ar1[0] = 7; ar2[0] = 7;
    @(negedge clk);
    chk("lit_after_r1", qa1, 32'hA5A5A5A5);
    chk("lit_after_r2", qa2, 32'hA5A5A5A5);

    // Ignored writes never forward; a valid port-2 write does.
    idle();
    wr[0] = 1; aw[0] = 0; dw[0] = 32'hFFFF; rd[0] = 1; ar1[0] = 0; ar2[0] = 0;
    wr[2] = 1; aw[2] = 20; dw[2] = 32'h1234; rd[2] = 1; ar1[2] = 20; ar2[2] = 20;
    @(negedge clk);
    chk("lit_nofwd_zero", qa1, 32'h0);
    chk("lit_nofwd_oor", qc1, 32'h0);
    idle(); wr[2] = 1; aw[2] = 3; dw[2] = 32'h77; rd[2] = 1; ar1[2] = 1; ar2[2] = 3;
    @(negedge clk);
    chk("lit_fwd_p2", qc2, BYP ? 32'h77 : 32'h0);

    // Top address of the 32-word bank.
    idle(); wr[0] = 1; aw[0] = 31; dw[0] = 32'h80000001;
    @(negedge clk);
    idle(); rd[0] = 1; ar1[0] = 31; ar2[0] = 30;
    @(negedge clk);
    chk("lit_top_r1", qa1, 32'h80000001);

    // Asynchronous reset between edges while VALID is high.
    idle(); wr[0] = 1; aw[0] = 9; dw[0] = 32'hFFFFFFFF;
    @(negedge clk);
    idle(); rd[0] = 1; ar1[0] = 9; ar2[0] = 9;
    @(negedge clk);
    chk("lit_pre_rst_r1", qa1, 32'hFFFFFFFF);
    chk("lit_pre_rst_v", 32'(va), 32'h1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_r1", qa1, 32'h0);
    chk("lit_async_r2", qa2, 32'h0);
    chk("lit_async_v", 32'(va), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd[0] = 1; ar1[0] = a; ar2[0] = 31 - a;
      rd[2] = 1; ar1[2] = a; ar2[2] = 31 - a;
      @(negedge clk);
      chk("lit_cleared_a", qa1 | qa2, 32'h0);
      chk("lit_cleared_c", qc1 | qc2, 32'h0);
    end

    // 8-bit x 4 bank: fill with 0xFF (upper input bits dropped), read back, then hold.
    idle();
    for (int a = 0; a < 4; a++) begin
      wr[1] = 1; aw[1] = a; dw[1] = 32'h1FF;
      @(negedge clk);
    end
    idle(); rd[1] = 1; ar1[1] = 0; ar2[1] = 1;
    @(negedge clk);
    chk("lit_b_0", 32'(qb1), 32'h0);
    chk("lit_b_1", 32'(qb2), 32'hFF);
    ar1[1] = 2; ar2[1] = 3;
    @(negedge clk);
    chk("lit_b_2", 32'(qb1), 32'hFF);
    chk("lit_b_3", 32'(qb2), 32'hFF);
    chk("lit_b_v_b2b", 32'(vb), 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_b_hold_r1", 32'(qb1), 32'hFF);
      chk("lit_b_hold_r2", 32'(qb2), 32'hFF);
      chk("lit_b_hold_v", 32'(vb), 32'h0);
    end

    // Mixed traffic with narrow address ranges to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      rd[0] = 1'($urandom); wr[0] = 1'($urandom);
      ar1[0] = $urandom_range(0, 7); ar2[0] = $urandom_range(0, 7);
      aw[0] = $urandom_range(0, 7); dw[0] = $urandom;
      rd[1] = 1'($urandom); wr[1] = 1'($urandom);
      ar1[1] = $urandom_range(0, 3); ar2[1] = $urandom_range(0, 3);
      aw[1] = $urandom_range(0, 3); dw[1] = $urandom;
      rd[2] = 1'($urandom); wr[2] = 1'($urandom);
      ar1[2] = $urandom_range(0, 31); ar2[2] = $urandom_range(0, 31);
      aw[2] = $urandom_range(0, 31); dw[2] = $urandom;
      @(negedge clk);
    end

    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_nxw.md
# reg_bank_nxw

Parametrised N-word × W-bit register bank with one write port and two registered read ports. It succeeds the fixed 32-bit `REG32`/decoder arrangement as the processor's general-purpose register file and sits between instruction decode and the ALU operand latches. Storage is clocked on the positive edge and reset asynchronously to zero. Read data is captured on a strobe and flagged with a one-cycle valid pulse.

## Interface
Parameters:
- `WIDTH`, 32, bits per word (≥1).
- `DEPTH`, 32, number of words (2..2^ADDR_W).
- `ADDR_W`, 5, address width.
- `ZERO_REG`, 1, when 1 word 0 is hardwired to zero and writes to it are discarded.

Ports:
- `CLK`  in  1  clock, positive edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `READ`  in  1  read strobe, sampled on `CLK`↑.
- `WRITE`  in  1  write strobe, sampled on `CLK`↑.
- `ADDR_R1`  in  ADDR_W  read port 1 address.
- `ADDR_R2`  in  ADDR_W  read port 2 address.
- `ADDR_W`  in  ADDR_W  write address.
- `DATA_W`  in  WIDTH  write data.
- `DATA_R1`  out  WIDTH  registered read data, port 1.
- `DATA_R2`  out  WIDTH  registered read data, port 2.
- `VALID`  out  1  one-cycle pulse: `DATA_R1`/`DATA_R2` were updated by the previous edge.

## Operation
- Reset (`RESET`=0, asynchronous):
  - all words ← 0;
  - `DATA_R1` = `DATA_R2` = 0;
  - `VALID` = 0.
  - Held for as long as `RESET`=0. Strobes are ignored during reset.
- Write: on `CLK`↑ with `WRITE`=1, word[`ADDR_W`] ← `DATA_W`. Exceptions:
  - `ADDR_W` ≥ `DEPTH`: write ignored.
  - `ZERO_REG`=1 and `ADDR_W`=0: write ignored.
- Read: on `CLK`↑ with `READ`=1, `DATA_R1` ← word[`ADDR_R1`] and `DATA_R2` ← word[`ADDR_R2`]. Rules:
  - Address ≥ `DEPTH` returns 0.
  - With `ZERO_REG`=1, address 0 returns 0.
  - `VALID` ← 1 on the same edge.
- `READ`=0 on an edge:
  - `DATA_R1`/`DATA_R2` hold their values.
  - `VALID` ← 0.
- Back-to-back `READ`=1 on consecutive edges keeps `VALID` high and refreshes data every cycle.
- Both read ports may address the same word; both return identical data.
- Same-edge `READ`/`WRITE` to the same address: the result is set by the configuration below.
- `WIDTH` arithmetic: none. Data passes through unmodified and is never sign-extended or truncated.

## Timing
- Write latency: 1 edge. Data written at edge k is visible to a read at edge k+1.
- Read latency: 1 edge. `DATA_R*`/`VALID` change only on `CLK`↑ or on `RESET` assertion.
- No combinational path from any input to any output.
- Reset deassertion is synchronous-safe: the first edge after `RESET`↑ may perform a read or write.
- `RESET` asserted mid-operation (any cycle) clears storage, outputs and `VALID` immediately, without waiting for a clock edge.

## Configuration
- `REG_BANK_BYPASS_EN` defined: write-through forwarding.
  - Same-edge `READ`=1 and `WRITE`=1 with `ADDR_R1`==`ADDR_W` makes `DATA_R1` capture `DATA_W`. Port 2 behaves the same way.
  - Forwarding is suppressed when the write itself is ignored (out of range, or zero register with `ZERO_REG`=1).
- Not defined: the read returns the pre-write (old) contents. The new value is visible from the next read edge.

## Test plan
- Reset, then `READ` with `ADDR_R1`=3, `ADDR_R2`=31 → next edge `DATA_R1`=0, `DATA_R2`=0, `VALID`=1.
- `WRITE` 0xDEADBEEF to 5, then `READ` R1=5, R2=5 → both 0xDEADBEEF, `VALID` pulses exactly one cycle.
- `ZERO_REG`=1: `WRITE` 0x12345678 to 0, then `READ` R1=0 → `DATA_R1`=0. With `DEPTH`=16, `WRITE` to 20 → no word changes.
- Same-edge `WRITE` 0xA5A5A5A5 to 7 with `READ` R1=7, where word 7 previously held 0x1 → `DATA_R1`=0xA5A5A5A5 with `REG_BANK_BYPASS_EN`, 0x00000001 without. The following read returns 0xA5A5A5A5 in both builds.
- Assert `RESET`=0 between edges while `VALID`=1 and `DATA_R1`=0xFFFFFFFF → outputs 0 immediately. A read after release returns 0 for every address.
- `WIDTH`=8, `DEPTH`=4, `ADDR_W`=2:
  - write 0xFF to each address, then read all of them → 0xFF everywhere, except address 0, which reads 0 when `ZERO_REG`=1.
  - `READ` held low for 3 cycles → outputs hold.
